// File: rtl/hk_fetch_sequencer_if.sv
// Bus between the HK fetch sequencer, the HK memory and the round datapath.
// The master modport is the sequencer; the slave modport is the memory/datapath side.
interface hk_fetch_sequencer_if;
    // HK memory side
    logic         hk_rdy;
    logic [31:0]  ram_dr;
    logic         copy_rom;
    logic         hk_selector;
    logic [2:0]   h_addr;
    logic [5:0]   k_addr;
    // Control and round-datapath side
    logic         start;
    logic         k_ready;
    logic [255:0] h_init;
    logic         h_valid;
    logic [31:0]  k_t;
    logic         k_valid;
    logic [5:0]   k_idx;
    logic         k_last;
    logic         busy;

    modport master (
        input  hk_rdy, ram_dr, start, k_ready,
        output copy_rom, hk_selector, h_addr, k_addr,
        output h_init, h_valid, k_t, k_valid, k_idx, k_last, busy
    );

    modport slave (
        output hk_rdy, ram_dr, start, k_ready,
        input  copy_rom, hk_selector, h_addr, k_addr,
        input  h_init, h_valid, k_t, k_valid, k_idx, k_last, busy
    );
endinterface

// File: rtl/hk_fetch_sequencer.sv
// Read-side master for the HK memory: requests the ROM->RAM copy after reset,
// then on each START loads H0..H(H_COUNT-1) into H_INIT and streams
// K0..K(K_COUNT-1) to the round datapath over a valid/ready handshake.
module hk_fetch_sequencer #(
    parameter int H_COUNT = 8,
    parameter int K_COUNT = 64
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    hk_fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_COPY     = 3'd0,
        S_IDLE     = 3'd1,
        S_LOAD_H   = 3'd2,
        S_K_FILL   = 3'd3,
        S_K_STREAM = 3'd4
    } state_t;

    localparam logic [2:0] H_LAST = 3'(H_COUNT - 1);
    localparam logic [5:0] K_LAST = 6'(K_COUNT - 1);

    state_t         state_q, state_d;
    logic           copy_rom_q, copy_rom_d;
    logic           hk_sel_q, hk_sel_d;
    logic [2:0]     h_addr_q, h_addr_d;
    logic [5:0]     k_addr_q, k_addr_d;
    logic [255:0]   h_init_q, h_init_d;
    logic           h_valid_q, h_valid_d;
    logic [31:0]    k_t_q, k_t_d;
    logic           k_valid_q, k_valid_d;
    logic [5:0]     k_idx_q, k_idx_d;
    logic           busy_q, busy_d;
    logic           k_hs;

    assign k_hs = k_valid_q && bus.k_ready;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_COPY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COPY:     if (bus.hk_rdy) state_d = S_IDLE;
            S_IDLE:     if (bus.start) state_d = S_LOAD_H;
            S_LOAD_H:   if (h_addr_q == H_LAST) state_d = S_K_FILL;
            S_K_FILL:   state_d = S_K_STREAM;
            S_K_STREAM: if (k_hs && (k_idx_q == K_LAST)) state_d = S_IDLE;
            default:    state_d = S_COPY;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        copy_rom_d = copy_rom_q;
        hk_sel_d   = hk_sel_q;
        h_addr_d   = h_addr_q;
        k_addr_d   = k_addr_q;
        h_init_d   = h_init_q;
        h_valid_d  = 1'b0;
        k_t_d      = k_t_q;
        k_valid_d  = k_valid_q;
        k_idx_d    = k_idx_q;
        case (state_q)
            S_COPY: begin
                copy_rom_d = !bus.hk_rdy;
            end
            S_IDLE: begin
                hk_sel_d = 1'b0;
                h_addr_d = 3'd0;
            end
            S_LOAD_H: begin
                // H0 occupies the top word of H_INIT
                for (int i = 0; i < 8; i++) begin
                    if ((i < H_COUNT) && (h_addr_q == 3'(i))) begin
                        h_init_d[255 - 32*i -: 32] = bus.ram_dr;
                    end
                end
                if (h_addr_q == H_LAST) begin
                    h_valid_d = 1'b1;
                    hk_sel_d  = 1'b1;
                    h_addr_d  = 3'd0;
                    k_addr_d  = 6'd0;
                end else begin
                    h_addr_d = h_addr_q + 3'd1;
                end
            end
            S_K_FILL: begin
                k_t_d     = bus.ram_dr;
                k_idx_d   = 6'd0;
                k_valid_d = 1'b1;
                k_addr_d  = (K_COUNT > 1) ? 6'd1 : 6'd0;
            end
            S_K_STREAM: begin
                if (k_hs) begin
                    if (k_idx_q == K_LAST) begin
                        k_valid_d = 1'b0;
                        hk_sel_d  = 1'b0;
                        k_addr_d  = 6'd0;
                        k_idx_d   = 6'd0;
                    end else begin
                        k_t_d   = bus.ram_dr;
                        k_idx_d = k_idx_q + 6'd1;
                        // The prefetch address stops at the last word so it never wraps
                        if (k_addr_q != K_LAST) begin
                            k_addr_d = k_addr_q + 6'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_LOAD_H) || (state_d == S_K_FILL) || (state_d == S_K_STREAM);
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            copy_rom_q <= 1'b0;
            hk_sel_q   <= 1'b0;
            h_addr_q   <= 3'd0;
            k_addr_q   <= 6'd0;
            h_init_q   <= '0;
            h_valid_q  <= 1'b0;
            k_t_q      <= '0;
            k_valid_q  <= 1'b0;
            k_idx_q    <= 6'd0;
            busy_q     <= 1'b0;
        end else begin
            copy_rom_q <= copy_rom_d;
            hk_sel_q   <= hk_sel_d;
            h_addr_q   <= h_addr_d;
            k_addr_q   <= k_addr_d;
            h_init_q   <= h_init_d;
            h_valid_q  <= h_valid_d;
            k_t_q      <= k_t_d;
            k_valid_q  <= k_valid_d;
            k_idx_q    <= k_idx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.copy_rom    = copy_rom_q;
    assign bus.hk_selector = hk_sel_q;
    assign bus.h_addr      = h_addr_q;
    assign bus.k_addr      = k_addr_q;
    assign bus.h_init      = h_init_q;
    assign bus.h_valid     = h_valid_q;
    assign bus.k_t         = k_t_q;
    assign bus.k_valid     = k_valid_q;
    assign bus.k_idx       = k_idx_q;
    assign bus.k_last      = k_valid_q && (k_idx_q == K_LAST);
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_hk_fetch_sequencer.sv
// Directed bench for hk_fetch_sequencer with a combinational HK memory model
// holding the SHA-256 initial hash values and round constants.
module tb_hk_fetch_sequencer;

    localparam logic [31:0] HTAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KTAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H_EXP = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    hk_fetch_sequencer_if bus ();

    hk_fetch_sequencer #(.H_COUNT(8), .K_COUNT(64)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // HK memory: data for the driven address is available within the same cycle
    assign bus.ram_dr = bus.hk_selector ? KTAB[bus.k_addr] : HTAB[bus.h_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"},
              {bus.copy_rom, bus.hk_selector, bus.h_valid, bus.k_valid, bus.k_last, bus.busy},
              6'b0);
        check({tag, "_addr"}, {bus.h_addr, bus.k_addr, bus.k_idx}, 15'd0);
        check({tag, "_kt"}, bus.k_t, 32'd0);
        check({tag, "_hinit"}, bus.h_init, 256'd0);
    endtask

    // One START: H load then K stream. rnd randomises K_READY, inj pulses START
    // mid-stream, abort_at >= 0 asserts reset when K_IDX reaches that index.
    task automatic run_block(input bit rnd, input bit inj, input int abort_at);
        int   n;
        int   e;
        int   cyc;
        bit   done;
        logic rdy;
        bus.k_ready = 1'b0;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.h_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hvalid_latency", 256'(n), 256'd9);
        check("h_init", bus.h_init, H_EXP);
        check("h_init_w0_w7", {bus.h_init[255:224], bus.h_init[31:0]}, {32'h6a09e667, 32'h5be0cd19});
        check("busy_load", bus.busy, 1'b1);
        @(negedge clk);
        check("hvalid_pulse_kvalid", {bus.h_valid, bus.k_valid}, 2'b01);
        e    = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 1000) begin
            check("kword",
                  {bus.k_valid, bus.k_last, bus.hk_selector, bus.k_idx, bus.k_t},
                  {1'b1, (e == 63), 1'b1, 6'(e), KTAB[e]});
            if (e == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("reset_mid_stream");
                return;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.k_ready = rdy;
            bus.start   = inj && (e == 10);
            @(posedge clk);
            if (rdy) begin
                if (e == 63) done = 1'b1;
                else e++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start   = 1'b0;
        bus.k_ready = 1'b0;
        check("stream_completed", done, 1'b1);
        check("stream_end", {bus.k_valid, bus.k_last, bus.busy, bus.hk_selector, bus.k_addr}, 10'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_stream", {bus.busy, bus.h_valid, bus.k_valid}, 3'b000);
        end
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.hk_rdy  = 1'b0;
        bus.start   = 1'b0;
        bus.k_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Copy request while the memory is not ready
        @(negedge clk);
        check("copy_rom_asserted", bus.copy_rom, 1'b1);
        repeat (3) @(negedge clk);
        check("copy_rom_held", {bus.copy_rom, bus.busy}, 2'b10);
        bus.hk_rdy = 1'b1;
        @(negedge clk);
        check("copy_rom_released", {bus.copy_rom, bus.busy}, 2'b00);
        check("idle_addr", {bus.hk_selector, bus.h_addr}, 4'd0);

        run_block(1'b0, 1'b0, -1);
        run_block(1'b1, 1'b1, -1);
        run_block(1'b0, 1'b0, -1);
        run_block(1'b1, 1'b0, 20);

        @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_copy_after_reset", {bus.copy_rom, bus.busy}, 2'b00);
        end
        run_block(1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
